// File: rtl/dds_wavegen_ch.sv
// Single-channel DDS waveform source: phase accumulator stepped by a sample
// divider, square/saw/triangle shaping, amplitude scaling, glitch-free reconfig.
module dds_wavegen_ch #(
  parameter int PHASE_W = 10,
  parameter int FREQ_W  = 6,
  parameter int AMP_W   = 4,
  parameter int OUT_W   = 8,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_freq,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [1:0]         cfg_mode,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               wrap
);

  localparam int PROD_W = OUT_W + AMP_W;
  localparam logic [PROD_W-1:0] AMP_MAX = PROD_W'((2 ** AMP_W) - 1);

  localparam logic [1:0] MODE_SQUARE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  // Config handshake: a transfer happens on a cycle where cfg_valid and
  // cfg_ready are both high; the source holds its fields until then.
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [FREQ_W-1:0]  freq_act_q, freq_sh_q;
  logic [AMP_W-1:0]   amp_act_q, amp_sh_q;
  logic [1:0]         mode_act_q, mode_sh_q;
  logic [DIV_W-1:0]   div_act_q, div_sh_q;
  logic               pending_q, pending_d;
  logic [OUT_W-1:0]   sample_q, sample_d;
  logic               valid_q, wrap_q, wrap_d;

  logic               tick;
  logic               carry;
  logic               accept;
  logic               apply;
  logic [PHASE_W:0]   sum;
  logic [OUT_W-1:0]   tri_t;
  logic [OUT_W-1:0]   raw;
  logic [PROD_W-1:0]  prod;
  logic [OUT_W-1:0]   scaled;

  assign tick   = enable && (div_cnt_q == div_act_q);
  assign sum    = {1'b0, phase_q} + (PHASE_W + 1)'(freq_act_q);
  assign carry  = sum[PHASE_W];
  assign accept = cfg_valid && !pending_q;
  // A phase_clr counts as a wrap, and an idle or frozen accumulator has no
  // wrap to wait for, so a pending config lands immediately in those cases.
  assign apply  = pending_q && ((tick && carry) || phase_clr || !enable ||
                                (freq_act_q == '0));

  assign tri_t = phase_q[PHASE_W-2 -: OUT_W];

  always_comb begin
    raw = '0;
    case (mode_act_q)
      MODE_SQUARE: raw = phase_q[PHASE_W-1] ? '1 : '0;
      MODE_SAW:    raw = phase_q[PHASE_W-1 -: OUT_W];
      MODE_TRI:    raw = phase_q[PHASE_W-1] ? ~tri_t : tri_t;
      default:     raw = '0;
    endcase
  end

  assign prod   = PROD_W'(raw) * PROD_W'(amp_act_q);
  assign scaled = OUT_W'(prod / AMP_MAX);

  always_comb begin
    phase_d = phase_q;
    if (phase_clr) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = sum[PHASE_W-1:0];
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (!enable || apply || tick) begin
      div_cnt_d = '0;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    sample_d = sample_q;
    if (tick) begin
      sample_d = scaled;
    end
  end

  assign wrap_d = tick && carry && !phase_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      div_cnt_q  <= '0;
      freq_act_q <= '0;
      amp_act_q  <= '0;
      mode_act_q <= '0;
      div_act_q  <= '0;
      freq_sh_q  <= '0;
      amp_sh_q   <= '0;
      mode_sh_q  <= '0;
      div_sh_q   <= '0;
      pending_q  <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      div_cnt_q <= div_cnt_d;
      pending_q <= pending_d;
      sample_q  <= sample_d;
      valid_q   <= tick;
      wrap_q    <= wrap_d;
      if (accept) begin
        freq_sh_q <= cfg_freq;
        amp_sh_q  <= cfg_amp;
        mode_sh_q <= cfg_mode;
        div_sh_q  <= cfg_div;
      end
      if (apply) begin
        freq_act_q <= freq_sh_q;
        amp_act_q  <= amp_sh_q;
        mode_act_q <= mode_sh_q;
        div_act_q  <= div_sh_q;
      end
    end
  end

  assign cfg_ready    = ~pending_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_dds_wavegen_ch.sv
// Directed bench for dds_wavegen_ch: stimulus pushes expected {wrap, sample}
// pairs, a negedge monitor pops and compares every presented sample.
module tb_dds_wavegen_ch;

  localparam int PHASE_W = 10;
  localparam int FREQ_W  = 6;
  localparam int AMP_W   = 4;
  localparam int OUT_W   = 8;
  localparam int DIV_W   = 8;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              phase_clr;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [FREQ_W-1:0] cfg_freq;
  logic [AMP_W-1:0]  cfg_amp;
  logic [1:0]        cfg_mode;
  logic [DIV_W-1:0]  cfg_div;
  logic [OUT_W-1:0]  sample_out;
  logic              sample_valid;
  logic              wrap;

  logic [OUT_W:0] exp_q[$];
  int checks;
  int failures;
  int sample_idx;

  dds_wavegen_ch #(
    .PHASE_W(PHASE_W), .FREQ_W(FREQ_W), .AMP_W(AMP_W),
    .OUT_W(OUT_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .phase_clr(phase_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_freq(cfg_freq),
    .cfg_amp(cfg_amp), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .sample_out(sample_out), .sample_valid(sample_valid), .wrap(wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample: got sample=%0d wrap=%0b, none expected",
                 sample_out, wrap);
      end else begin
        logic [OUT_W:0] e;
        e = exp_q.pop_front();
        if ({wrap, sample_out} !== e) begin
          failures++;
          $display("FAIL sample_%0d: got sample=%0d wrap=%0b, expected sample=%0d wrap=%0b",
                   sample_idx, sample_out, wrap, e[OUT_W-1:0], e[OUT_W]);
        end
      end
      sample_idx++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int s, input bit w);
    logic [OUT_W-1:0] sv;
    sv = OUT_W'(s);
    exp_q.push_back({w, sv});
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cfg_ready && n < 20) begin
      step();
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL %s: cfg_ready stayed 0 for 20 cycles, expected 1", name);
    end
  endtask

  task automatic send_cfg(input int f, input int a, input int m, input int d);
    wait_ready("cfg_ready_before_accept");
    cfg_freq  = FREQ_W'(f);
    cfg_amp   = AMP_W'(a);
    cfg_mode  = 2'(m);
    cfg_div   = DIV_W'(d);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    wait_ready("cfg_ready_after_apply");
  endtask

  task automatic clr_phase();
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    step();
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    repeat (n) step();
    enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    sample_idx = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    phase_clr  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_freq   = '0;
    cfg_amp    = '0;
    cfg_mode   = '0;
    cfg_div    = '0;
    #12;
    check("reset_sample_out", sample_out, 0);
    check("reset_sample_valid", sample_valid, 0);
    check("reset_wrap", wrap, 0);
    check("reset_cfg_ready", cfg_ready, 1);
    step();
    reset = 1'b0;
    repeat (3) step();

    // sawtooth, tick every cycle: 0,4,...,252 then 0, wrap on the 64th
    send_cfg(16, 15, 1, 0);
    clr_phase();
    for (int i = 0; i < 64; i++) push(i * 4, i == 63);
    push(0, 1'b0);
    run(65);
    check("drain_saw", exp_q.size(), 0);

    // divider 3: a strobe every 4th cycle, sample_out frozen while disabled
    send_cfg(16, 15, 1, 3);
    clr_phase();
    for (int i = 0; i < 4; i++) push(i * 4, 1'b0);
    enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      check($sformatf("div_strobe_c%0d", c), sample_valid, (c % 4 == 0) ? 1 : 0);
    end
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("freeze_out_%0d", c), sample_out, 12);
      check($sformatf("freeze_valid_%0d", c), sample_valid, 0);
    end
    check("drain_div", exp_q.size(), 0);

    // square, amp 5: 16 x 0 then 16 x floor(255*5/15) = 85
    send_cfg(32, 5, 0, 0);
    clr_phase();
    for (int i = 0; i < 32; i++) push((i < 16) ? 0 : 85, i == 31);
    run(32);
    check("drain_square", exp_q.size(), 0);

    // square, amp 0: everything zero
    send_cfg(32, 0, 0, 0);
    clr_phase();
    for (int i = 0; i < 32; i++) push(0, i == 31);
    run(32);
    check("drain_square_amp0", exp_q.size(), 0);

    // triangle: 0..240 up, 255..15 down with wrap on 15, then 0
    send_cfg(32, 15, 2, 0);
    clr_phase();
    for (int i = 0; i < 16; i++) push(i * 16, 1'b0);
    for (int i = 0; i < 16; i++) push(255 - i * 16, i == 15);
    push(0, 1'b0);
    run(33);
    check("drain_triangle", exp_q.size(), 0);

    // mid-period reconfig: step 4 until the wrap, step 8 afterwards
    send_cfg(16, 15, 1, 0);
    clr_phase();
    for (int i = 0; i < 64; i++) push(i * 4, i == 63);
    for (int j = 0; j < 32; j++) push(j * 8, j == 31);
    enable = 1'b1;
    repeat (10) step();
    cfg_freq  = 6'd32;
    cfg_amp   = 4'd15;
    cfg_mode  = 2'b01;
    cfg_div   = 8'd0;
    cfg_valid = 1'b1;
    step();
    check("reconfig_ready_low_after_accept", cfg_ready, 0);
    cfg_freq = 6'd8;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("reconfig_ignored_ready_%0d", k), cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    repeat (49) step();
    check("reconfig_ready_before_wrap", cfg_ready, 0);
    step();
    check("reconfig_ready_after_wrap", cfg_ready, 1);
    repeat (32) step();
    enable = 1'b0;
    step();
    step();
    check("drain_reconfig", exp_q.size(), 0);

    // asynchronous reset mid-run with a config pending
    send_cfg(16, 15, 1, 0);
    clr_phase();
    for (int i = 0; i < 5; i++) push(i * 4, 1'b0);
    enable = 1'b1;
    repeat (5) step();
    cfg_freq  = 6'd32;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("rst_pending_ready", cfg_ready, 0);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("rst_async_sample_out", sample_out, 0);
    check("rst_async_valid", sample_valid, 0);
    check("rst_async_wrap", wrap, 0);
    check("rst_async_ready", cfg_ready, 1);
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    check("rst_idle_ready", cfg_ready, 1);
    check("rst_idle_out", sample_out, 0);
    check("drain_reset", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
